afpm_operand_loader: RTL and testbench

//  - Upstream stage of the logarithmic approximate FP16 multiplier.
//  - The pad interface is only 8 bits wide, so this block assembles two FP16 operands from four byte strobes.
//  - It pre-classifies IEEE special cases and presents the operand pair to the multiplier with a valid/ready handshake.
//  - The multiplier then works only on normal operands and uses the class hint for zero/inf/NaN results.

---
 rtl/afpm_operand_loader.sv | 157 +++++++++++++++
 tb/tb_afpm_operand_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/afpm_operand_loader.sv
// rtl/afpm_operand_loader.sv - assembles two FP16 operands from byte strobes, pre-classifies them, hands the pair over valid/ready
module afpm_operand_loader #(
    parameter int FLUSH_SUBNORM = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        soft_clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_stb,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  res_class,
    output logic        res_sign,
    output logic [1:0]  byte_cnt,
    output logic        overrun,
    output logic        err_timeout
);

    typedef enum logic [2:0] {S_AH, S_AL, S_BH, S_BL, S_ISSUE} state_t;

    // The idle counter only has to reach TIMEOUT-1: expiry is the TIMEOUT-th idle cycle.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_n;
    logic [7:0]    a_hi, a_lo, b_hi;
    logic [CW-1:0] idle_cnt;
    logic          accept, ovr_n, to_n, cnt_clr, cnt_inc;
    logic [15:0]   new_a, new_b;
    logic          a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [1:0]    class_n;

    function automatic logic [15:0] flush_op(input logic [15:0] x);
        flush_op = x;
        if (FLUSH_SUBNORM != 0 && x[14:10] == 5'd0)
            flush_op[9:0] = 10'd0;
    endfunction

    assign new_a  = flush_op({a_hi, a_lo});
    assign new_b  = flush_op({b_hi, byte_in});
    assign a_nan  = (&new_a[14:10]) & (|new_a[9:0]);
    assign a_inf  = (&new_a[14:10]) & ~(|new_a[9:0]);
    assign a_zero = ~(|new_a[14:0]);
    assign b_nan  = (&new_b[14:10]) & (|new_b[9:0]);
    assign b_inf  = (&new_b[14:10]) & ~(|new_b[9:0]);
    assign b_zero = ~(|new_b[14:0]);

    always_comb begin
        class_n = 2'd0;
        if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf))
            class_n = 2'd3;
        else if (a_inf | b_inf)
            class_n = 2'd2;
        else if (a_zero | b_zero)
            class_n = 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_AH;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        ovr_n   = 1'b0;
        to_n    = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (soft_clr) begin
            state_n = S_AH;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (op_ready)
                        state_n = S_AH;
                    ovr_n = byte_stb;
                end
                S_AH: begin
                    if (byte_stb) begin
                        accept  = 1'b1;
                        state_n = S_AL;
                    end
                end
                S_AL, S_BH, S_BL: begin
                    if (byte_stb) begin
                        accept  = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = state_t'(state + 3'd1);
                    end else if (TIMEOUT > 0 && idle_cnt == CNT_LAST) begin
                        state_n = S_AH;
                        to_n    = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_n = S_AH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hi        <= 8'd0;
            a_lo        <= 8'd0;
            b_hi        <= 8'd0;
            op_a        <= 16'd0;
            op_b        <= 16'd0;
            res_class   <= 2'd0;
            res_sign    <= 1'b0;
            overrun     <= 1'b0;
            err_timeout <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            if (accept) begin
                case (state)
                    S_AH:    a_hi <= byte_in;
                    S_AL:    a_lo <= byte_in;
                    S_BH:    b_hi <= byte_in;
                    default: ;
                endcase
            end
            // The fourth byte goes straight into op_b without an intermediate register.
            if (accept && state == S_BL) begin
                op_a      <= new_a;
                op_b      <= new_b;
                res_class <= class_n;
                res_sign  <= new_a[15] ^ new_b[15];
            end
            overrun     <= ovr_n;
            err_timeout <= to_n;
            if (cnt_clr)
                idle_cnt <= '0;
            else if (cnt_inc && idle_cnt != '1)
                idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign op_valid = (state == S_ISSUE);

    always_comb begin
        case (state)
            S_AL:    byte_cnt = 2'd1;
            S_BH:    byte_cnt = 2'd2;
            S_BL:    byte_cnt = 2'd3;
            default: byte_cnt = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_afpm_operand_loader.sv
// tb/tb_afpm_operand_loader.sv - scoreboard bench for afpm_operand_loader with a byte-stream reference model
module tb_afpm_operand_loader;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        soft_clr = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_stb = 1'b0;
    logic        op_ready = 1'b0;
    logic [15:0] op_a, op_b;
    logic        op_valid, res_sign, overrun, err_timeout;
    logic [1:0]  res_class, byte_cnt;

    always #5 clk = ~clk;

    afpm_operand_loader #(.FLUSH_SUBNORM(1), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .soft_clr(soft_clr), .byte_in(byte_in), .byte_stb(byte_stb),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .res_class(res_class), .res_sign(res_sign), .byte_cnt(byte_cnt),
        .overrun(overrun), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  cls;
        logic        sgn;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    int         m_k = 0;
    int         m_gap = 0;
    bit         m_pending = 0;
    bit         m_ovr_now = 0;
    bit         m_to_now = 0;
    logic [7:0] m_buf [4];
    logic [15:0] cur_a, cur_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ref_flush(input logic [15:0] x);
        int e;
        e = (int'(x) >> 10) % 32;
        return (e == 0) ? (x & 16'h8000) : x;
    endfunction

    // 0 normal, 1 zero, 2 inf, 3 nan
    function automatic int ref_kind(input logic [15:0] x);
        int e, m;
        e = (int'(x) >> 10) % 32;
        m = int'(x) % 1024;
        if (e == 31) return (m != 0) ? 3 : 2;
        if (e == 0 && m == 0) return 1;
        return 0;
    endfunction

    function automatic exp_t ref_pair(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        int ka, kb;
        r.a = ref_flush(a);
        r.b = ref_flush(b);
        ka = ref_kind(r.a);
        kb = ref_kind(r.b);
        if (ka == 3 || kb == 3 || (ka == 2 && kb == 1) || (ka == 1 && kb == 2)) r.cls = 2'd3;
        else if (ka == 2 || kb == 2) r.cls = 2'd2;
        else if (ka == 1 || kb == 1) r.cls = 2'd1;
        else r.cls = 2'd0;
        r.sgn = a[15] ^ b[15];
        return r;
    endfunction

    // Scoreboard monitor: every cycle with op_valid must present the head pair.
    always @(negedge clk) begin
        if (!rst && op_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid actual=1 required=0 t=%0t", $time);
            end else begin
                chk("pair", {op_a, op_b, res_class, res_sign},
                    {sb[0].a, sb[0].b, sb[0].cls, sb[0].sgn});
                if (op_ready && !soft_clr) void'(sb.pop_front());
            end
        end
    end

    // Called at posedge+1; checks this cycle's control outputs then advances the model.
    task automatic cycle(input bit stb, input logic [7:0] b, input bit rdy, input bit clr);
        byte_stb = stb;
        byte_in  = b;
        op_ready = rdy;
        soft_clr = clr;
        @(negedge clk);
        chk("op_valid", op_valid, m_pending);
        chk("byte_cnt", byte_cnt, m_pending ? 0 : m_k);
        chk("overrun", overrun, m_ovr_now);
        chk("err_timeout", err_timeout, m_to_now);
        #1;
        m_ovr_now = 0;
        m_to_now  = 0;
        if (clr) begin
            if (m_pending) void'(sb.pop_back());
            m_pending = 0;
            m_k = 0;
            m_gap = 0;
        end else if (m_pending) begin
            if (stb) m_ovr_now = 1;
            if (rdy) m_pending = 0;
        end else if (stb) begin
            m_buf[m_k] = b;
            m_gap = 0;
            if (m_k == 3) begin
                sb.push_back(ref_pair({m_buf[0], m_buf[1]}, {m_buf[2], b}));
                m_pending = 1;
                m_k = 0;
            end else begin
                m_k++;
            end
        end else if (m_k > 0) begin
            m_gap++;
            if (m_gap == TO) begin
                m_to_now = 1;
                m_k = 0;
                m_gap = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        cycle(1, a[15:8], 0, 0);
        cycle(1, a[7:0], 0, 0);
        cycle(1, b[15:8], 0, 0);
        cycle(1, b[7:0], 0, 0);
    endtask

    task automatic special(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ea, input logic [1:0] ec, input logic es);
        load(a, b);
        chk("special_op_a", op_a, ea);
        chk("special_class", res_class, ec);
        chk("special_sign", res_sign, es);
        cycle(0, 8'h00, 1, 0);
    endtask

    function automatic logic [15:0] pick_op();
        case ($urandom_range(0, 11))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return 16'h7E00;
            5: return 16'h0001;
            6: return 16'h83FF;
            7: return 16'h3C00;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {op_a, op_b, op_valid, res_class, res_sign, byte_cnt, overrun, err_timeout}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic load, released immediately.
        load(16'h3E00, 16'h4200);
        chk("basic_op_a", op_a, 16'h3E00);
        chk("basic_op_b", op_b, 16'h4200);
        chk("basic_class_sign", {res_class, res_sign}, 3'b000);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        // Backpressure with a dropped byte.
        load(16'h3E00, 16'h4200);
        for (int i = 0; i < 10; i++) cycle(i == 3, 8'h55, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h11, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 1);

        special(16'h7C00, 16'h0000, 16'h7C00, 2'd3, 1'b0);
        special(16'hFC00, 16'h3C00, 16'hFC00, 2'd2, 1'b1);
        special(16'h0001, 16'h3C00, 16'h0000, 2'd1, 1'b0);
        special(16'h7E00, 16'h3C00, 16'h7E00, 2'd3, 1'b0);

        // Timeout after two bytes, then a clean load.
        cycle(1, 8'h3C, 0, 0);
        cycle(1, 8'h00, 0, 0);
        for (int i = 0; i < TO; i++) cycle(0, 8'h00, 0, 0);
        chk("timeout_pulse", err_timeout, 1'b1);
        chk("timeout_byte_cnt", byte_cnt, 2'd0);
        cycle(0, 8'h00, 0, 0);
        load(16'h4000, 16'hC000);
        cycle(0, 8'h00, 1, 0);

        // A byte on the expiry cycle is accepted.
        cycle(1, 8'h3C, 0, 0);
        for (int i = 0; i < TO - 1; i++) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h00, 0, 0);
        cycle(1, 8'h3C, 0, 0);
        cycle(1, 8'h01, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // soft_clr with op_valid and op_ready together discards the pair.
        load(16'h1234, 16'h5678);
        cycle(1, 8'hAA, 1, 1);
        cycle(0, 8'h00, 1, 0);

        // Asynchronous reset in the middle of a load.
        cycle(1, 8'h44, 0, 0);
        cycle(1, 8'h55, 0, 0);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {op_a, op_b, op_valid, res_class, res_sign, byte_cnt, overrun, err_timeout}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_k = 0; m_gap = 0; m_pending = 0; m_ovr_now = 0; m_to_now = 0;
        cycle(0, 8'h00, 0, 0);

        // Randomized traffic.
        cur_a = pick_op();
        cur_b = pick_op();
        for (int n = 0; n < 3000; n++) begin
            bit stb, rdy, clr;
            logic [7:0] b;
            logic [31:0] word;
            if (m_k == 0 && !m_pending) begin
                cur_a = pick_op();
                cur_b = pick_op();
            end
            word = {cur_a, cur_b};
            stb = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 63) == 0);
            b = m_pending ? 8'($urandom) : word[8*(3-m_k) +: 8];
            cycle(stb, b, rdy, clr);
        end

        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
